// File: rtl/mem_stage.sv
// Memory-access stage between the execute ALU and writeback. It issues loads and stores over a req/gnt/rvalid
// data-memory port with byte-lane alignment, load extension and a bus timeout. Other instructions pass through.
module mem_stage #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       alu_out,
    input  logic [31:0]       store_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rd,
    input  logic              reg_write,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic [4:0]        wb_rd,
    output logic              wb_reg_write,
    output logic              mem_fault,
    output logic [1:0]        state_dbg
);

    // Handshake: an instruction transfers on a cycle where in_valid && in_ready; in_ready is high only in IDLE,
    // dmem_req stays high until the cycle dmem_gnt is seen, and wb_valid is a single-cycle completion pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic             op_load;
    logic [2:0]       op_f3;
    logic [31:0]      op_addr;
    logic [4:0]       op_rd;
    logic             op_rw;

    logic        accept;
    logic        is_mem;
    logic        f3_ok;
    logic        misalign;
    logic        illegal;
    logic        tmo_hit;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign in_ready  = (state == IDLE);
    assign state_dbg = state;
    assign accept    = in_valid && in_ready;
    assign is_mem    = mem_read || mem_write;
    assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

    always_comb begin
        f3_ok = 1'b0;
        if (mem_read && !mem_write)
            f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
        else if (mem_write && !mem_read)
            f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        // funct3[1:0] encodes the access size for both loads and stores
        misalign = ((funct3[1:0] == 2'b01) && alu_out[0]) ||
                   ((funct3[1:0] == 2'b10) && (alu_out[1:0] != 2'b00));
        illegal  = (mem_read && mem_write) || !f3_ok || misalign;
    end

    always_comb begin
        st_wdata = store_data;
        st_wstrb = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                st_wdata = {4{store_data[7:0]}};
                st_wstrb = 4'b0001 << alu_out[1:0];
            end
            2'b01: begin
                st_wdata = {2{store_data[15:0]}};
                st_wstrb = 4'b0011 << alu_out[1:0];
            end
            default: begin
                st_wdata = store_data;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        case (op_addr[1:0])
            2'b00:   ld_byte = dmem_rdata[7:0];
            2'b01:   ld_byte = dmem_rdata[15:8];
            2'b10:   ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = op_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (op_f3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            tmo_cnt      <= '0;
            op_load      <= 1'b0;
            op_f3        <= 3'd0;
            op_addr      <= 32'd0;
            op_rd        <= 5'd0;
            op_rw        <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= 32'd0;
            dmem_wstrb   <= 4'd0;
            wb_valid     <= 1'b0;
            wb_data      <= 32'd0;
            wb_rd        <= 5'd0;
            wb_reg_write <= 1'b0;
            mem_fault    <= 1'b0;
        end else begin
            wb_valid  <= 1'b0;
            mem_fault <= 1'b0;
            tmo_cnt   <= tmo_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_load <= mem_read;
                        op_f3   <= funct3;
                        op_addr <= alu_out;
                        op_rd   <= rd;
                        op_rw   <= reg_write;
                        if (!is_mem) begin
                            wb_valid     <= 1'b1;
                            wb_data      <= alu_out;
                            wb_rd        <= rd;
                            wb_reg_write <= reg_write;
                        end else if (illegal) begin
                            wb_valid     <= 1'b1;
                            mem_fault    <= 1'b1;
                            wb_data      <= alu_out;
                            wb_rd        <= rd;
                            wb_reg_write <= 1'b0;
                        end else begin
                            state      <= REQ;
                            tmo_cnt    <= '0;
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_write;
                            dmem_addr  <= {alu_out[ADDR_W-1:2], 2'b00};
                            dmem_wdata <= st_wdata;
                            dmem_wstrb <= mem_write ? st_wstrb : 4'd0;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        dmem_wstrb <= 4'd0;
                        if (op_load) begin
                            state   <= RESP;
                            tmo_cnt <= '0;
                        end else begin
                            state        <= IDLE;
                            wb_valid     <= 1'b1;
                            wb_data      <= op_addr;
                            wb_rd        <= op_rd;
                            wb_reg_write <= 1'b0;
                        end
                    end else if (tmo_hit) begin
                        state        <= IDLE;
                        dmem_req     <= 1'b0;
                        dmem_we      <= 1'b0;
                        dmem_wstrb   <= 4'd0;
                        wb_valid     <= 1'b1;
                        mem_fault    <= 1'b1;
                        wb_data      <= op_addr;
                        wb_rd        <= op_rd;
                        wb_reg_write <= 1'b0;
                    end
                end
                RESP: begin
                    // A response arriving on the timeout cycle still completes the load normally
                    if (dmem_rvalid) begin
                        state        <= IDLE;
                        wb_valid     <= 1'b1;
                        wb_data      <= ld_data;
                        wb_rd        <= op_rd;
                        wb_reg_write <= op_rw;
                    end else if (tmo_hit) begin
                        state        <= IDLE;
                        wb_valid     <= 1'b1;
                        mem_fault    <= 1'b1;
                        wb_data      <= op_addr;
                        wb_rd        <= op_rd;
                        wb_reg_write <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute ALU. It consumes the ALU result and forwards it to writeback.
- It performs loads and stores against a single-port data memory using a req/gnt/rvalid handshake, with byte-lane alignment, sign/zero extension and a bus timeout.
- Non-memory instructions pass through with one register stage. Only one memory transaction is outstanding at a time.

Parameters:
- ADDR_W, 32, width of the data-memory address.
- TIMEOUT_CYCLES, 255, maximum cycles spent waiting in REQ or RESP before a fault is raised; 0 disables the timeout.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  stage can accept; high only in IDLE.
- alu_out  in  32  ALU result: effective address for memory ops, writeback value otherwise.
- store_data  in  32  rs2 value used by stores.
- mem_read  in  1  instruction is a load.
- mem_write  in  1  instruction is a store.
- funct3  in  3  access size and signedness.
- rd  in  5  destination register.
- reg_write  in  1  instruction writes rd.
- dmem_req  out  1  memory request; held until granted.
- dmem_we  out  1  1 = store.
- dmem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
- dmem_wdata  out  32  store data replicated across byte lanes.
- dmem_wstrb  out  4  store byte enables.
- dmem_gnt  in  1  memory accepts the request this cycle.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  32  read data.
- wb_valid  out  1  one-cycle completion pulse to writeback.
- wb_data  out  32  writeback value.
- wb_rd  out  5  writeback destination register.
- wb_reg_write  out  1  writeback enable; forced to 0 on a fault and for stores.
- mem_fault  out  1  qualifies wb_valid: misaligned access, illegal funct3, both mem_read and mem_write set, or timeout.

Behaviour:
- Reset: state=IDLE; outputs dmem_req, dmem_we, dmem_wstrb, wb_valid, wb_reg_write and mem_fault = 0; wb_data, wb_rd and dmem_addr = 0; timeout counter = 0. Reset mid-transaction aborts it with no wb_valid. A dmem_rvalid arriving after reset is ignored.
- Accept: an instruction is accepted when in_valid & in_ready. All inputs are registered on accept.
- Non-memory op (mem_read=mem_write=0) accepted in cycle N:
  - wb_valid=1 in N+1 with wb_data=alu_out and wb_reg_write=reg_write.
  - The stage remains in IDLE, giving back-to-back throughput of 1 per cycle.
- Access legality:
  - Loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: funct3 000 SB, 001 SH, 010 SW.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Fault cases (illegal funct3, misaligned, or mem_read & mem_write): no memory request is issued. wb_valid=1 and mem_fault=1 in N+1, wb_reg_write=0, wb_data=alu_out, stay in IDLE.
- FSM states: IDLE, REQ, RESP.
  - IDLE -> REQ on accepting a legal memory op.
  - REQ: dmem_req=1; dmem_addr, dmem_we, dmem_wdata and dmem_wstrb are stable until the gnt cycle.
    - Store, dmem_gnt=1: wb_valid pulse next cycle (wb_reg_write=0), -> IDLE.
    - Load, dmem_gnt=1: -> RESP; dmem_req drops next cycle.
  - RESP: wait for dmem_rvalid.
    - On dmem_rvalid: extract the lane selected by addr[1:0], sign- or zero-extend, wb_valid pulse next cycle with wb_reg_write=reg_write, -> IDLE.
    - dmem_rvalid seen in REQ or IDLE is ignored.
- Store lanes (little-endian):
  - SB: wdata={4{b}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{h}}, wstrb=4'b0011<<addr[1:0].
  - SW: wstrb=4'b1111.
- Load extraction (little-endian):
  - LB: rdata byte at addr[1:0], sign-extended.
  - LBU: same byte, zero-extended.
  - LH/LHU: halfword at addr[1], sign- or zero-extended.
  - LW: the full word.
- Timeout:
  - The counter clears on entering REQ or RESP and increments each cycle spent there.
  - When count == TIMEOUT_CYCLES-1 and the awaited event is absent: dmem_req drops, wb_valid=1 with mem_fault=1 and wb_reg_write=0 next cycle, -> IDLE.
  - If the event and the timeout coincide, the event wins.
- Output timing: wb_valid is high for exactly one cycle per accepted instruction. All wb_* fields hold their value until the next wb_valid.
- Latency (gnt and rvalid arriving immediately):
  - Load: accept N, req N+1, gnt N+1, rvalid N+2, wb_valid N+3.
  - Store: wb_valid N+2.

Test Plan:
- Non-memory op: three back-to-back ALU ops (alu_out=5, 6, 7; rd=1, 2, 3) -> wb_valid in 3 consecutive cycles carrying 5, 6, 7; in_ready stays 1 throughout.
- LB at addr 0x1003, rdata=0x80FF_1234, gnt after 2 wait cycles, rvalid 1 cycle later:
  - dmem_addr=0x1000, dmem_req held 3 cycles, wb_data=0xFFFF_FF80.
  - The same access as LBU gives 0x0000_0080.
- SH at addr 0x2002 with store_data=0xABCD_5678 -> dmem_wdata=0x5678_5678, dmem_wstrb=4'b1100, dmem_we=1, wb_valid with wb_reg_write=0.
- Faults:
  - LW at addr 0x3001 -> no dmem_req, mem_fault=1 next cycle.
  - funct3=011 load -> mem_fault=1.
  - mem_read=mem_write=1 -> mem_fault=1.
- Timeout with TIMEOUT_CYCLES=4 and a load that never sees rvalid -> mem_fault pulse 4 cycles after entering RESP, return to IDLE. A later rvalid is ignored.
- Reset asserted in RESP -> IDLE next cycle with no wb_valid; the next load completes normally.
